// File: rtl/serial_add_sched_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial add scheduler:
//   - state_t : FSM encoding (IDLE, ADD, DONE)
//   - DEFAULT_WIDTH / DEFAULT_NREQ : default operand width and requester count
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sched_if.sv
// serial_add_sched_if
//   Bundles the requester and result-side signals of serial_add_sched.
//   req       : per-requester add request (level)
//   a_in/b_in : packed operands, slice i belongs to requester i
//   gnt       : one-hot, one-cycle grant pulse
//   busy      : scheduler not idle
//   res_valid / res_ready : result handshake
//   res, res_cout, res_id : sum, carry out and owning requester
//   Modports: master = requester/consumer side, slave = scheduler side.
interface serial_add_sched_if
    import serial_add_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;

    modport master (
        output req, a_in, b_in, res_ready,
        input  gnt, busy, res_valid, res, res_cout, res_id
    );

    modport slave (
        input  req, a_in, b_in, res_ready,
        output gnt, busy, res_valid, res, res_cout, res_id
    );

endinterface

// File: rtl/serial_add_sched_core.sv
// serial_add_core
//   Bit-serial ripple adder datapath, LSB first.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture a_in/b_in, clear carry, counter and result
//   step       : process one bit; the sum bit enters res at the MSB end
//   a_in, b_in : operands to capture on load
//   res        : result shift register (full sum once last_bit is high)
//   cout       : running carry (final carry once last_bit is high)
//   last_bit   : all WIDTH bits have been processed
module serial_add_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             last_bit
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sum_bit;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
        if (load) begin
            a_d     = a_in;
            b_d     = b_in;
            res_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (step) begin
            // After WIDTH shifts the first (LSB) sum bit has reached res[0].
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res      = res_q;
    assign cout     = carry_q;
    assign last_bit = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched
//   Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : serial_add_sched_if.slave (requests, operands, grant,
//                busy, result handshake and result fields)
//   Timeline: capture edge -> gnt pulse for one cycle -> WIDTH bit steps
//   -> DONE on the (WIDTH+1)-th edge after capture -> wait for res_ready.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    serial_add_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand_idx;
    int               cand;

    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_res;
    logic             core_cout;
    logic             core_last;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Round-robin search: first asserted req at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign a_sel = bus.a_in[int'(win_idx)*WIDTH +: WIDTH];
    assign b_sel = bus.b_in[int'(win_idx)*WIDTH +: WIDTH];

    // The ADD state stays one edge past the last bit step so that DONE
    // lands WIDTH+1 edges after capture, with the full sum already in res.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        gnt_d     = '0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    core_load      = 1'b1;
                    gnt_d[win_idx] = 1'b1;
                    id_d           = win_idx;
                    state_d        = ADD;
                end
            end
            ADD: begin
                if (core_last) begin
                    state_d = DONE;
                end else begin
                    core_step = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                    if (int'(id_q) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = id_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
        end
    end

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .a_in     (a_sel),
        .b_in     (b_sel),
        .res      (core_res),
        .cout     (core_cout),
        .last_bit (core_last)
    );

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res       = core_res;
    assign bus.res_cout  = core_cout;
    assign bus.res_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched
//   Self-checking bench for serial_add_sched (NREQ=4, WIDTH=8): a table of
//   single-operation vectors plus hand-written sequences for backpressure,
//   round-robin rotation, reset during ADD and requests raised while busy.
module tb_serial_add_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_res;
        logic        exp_cout;
        logic [1:0]  exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    vec_t vecs [0:5];

    serial_add_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    serial_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock and a cycle counter for grant spacing
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b);
        bus.req  = r;
        bus.a_in = a;
        bus.b_in = b;
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the first negedge showing a grant (g=0 on timeout)
    task automatic waitGnt(output logic [3:0] g, output int waited);
        g      = '0;
        waited = 0;
        while (waited < 40) begin
            @(negedge clk);
            waited++;
            if (bus.gnt != '0) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    // Called at the grant negedge; counts negedges until res_valid
    task automatic waitResult(output int lat, output int extra);
        lat   = 0;
        extra = 0;
        while (!bus.res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.gnt != '0) extra++;
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] exp_gnt, input logic [7:0] exp_res,
                         input logic exp_cout, input logic [1:0] exp_id, input logic [3:0] req_after);
        logic [3:0] g;
        int         w;
        int         lat;
        int         extra;
        waitGnt(g, w);
        checkOutput({name, " gnt"}, 32'(g), 32'(exp_gnt));
        bus.req = req_after;
        waitResult(lat, extra);
        checkOutput({name, " latency"}, lat, 9);
        checkOutput({name, " extra gnt"}, extra, 0);
        checkOutput({name, " res"}, 32'(bus.res), 32'(exp_res));
        checkOutput({name, " cout"}, 32'(bus.res_cout), 32'(exp_cout));
        checkOutput({name, " id"}, 32'(bus.res_id), 32'(exp_id));
    endtask

    initial begin
        logic [3:0] g;
        int         w;
        int         prev_cyc;
        int         quiet;

        vecs[0] = '{"basic",    4'b0001, 32'h0000005A, 32'h0000003C, 4'b0001, 8'h96, 1'b0, 2'd0};
        vecs[1] = '{"carry",    4'b0010, 32'h0000FF00, 32'h00000100, 4'b0010, 8'h00, 1'b1, 2'd1};
        vecs[2] = '{"msb",      4'b1000, 32'h80000000, 32'h80000000, 4'b1000, 8'h00, 1'b1, 2'd3};
        vecs[3] = '{"rr pick0", 4'b0101, 32'h00AA0012, 32'h00BB0034, 4'b0001, 8'h46, 1'b0, 2'd0};
        vecs[4] = '{"rr pick2", 4'b0101, 32'h00C80077, 32'h00640066, 4'b0100, 8'h2C, 1'b1, 2'd2};
        vecs[5] = '{"rr wrap",  4'b0011, 32'h0000330F, 32'h00004401, 4'b0001, 8'h10, 1'b0, 2'd0};

        rst_n         = 1'b0;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.res_ready = 1'b1;
        #1;
        checkOutput("reset outputs",
                    {19'd0, bus.gnt, bus.busy, bus.res_valid, bus.res_cout, bus.res_id, bus.res}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations; pointer carries over between rows
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].req, vecs[i].a, vecs[i].b);
            runOp(vecs[i].name, vecs[i].exp_gnt, vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_id, 4'b0000);
            @(negedge clk);
            checkOutput({vecs[i].name, " idle"}, {30'd0, bus.busy, bus.res_valid}, 32'd0);
        end

        // Backpressure: result held for 5 cycles with res_ready low
        doReset();
        bus.res_ready = 1'b0;
        applyStimulus(4'b0001, 32'h00000021, 32'h00000013);
        runOp("bp", 4'b0001, 8'h34, 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp hold",
                        {19'd0, bus.res_valid, bus.busy, bus.res_cout, bus.res_id, bus.res},
                        {19'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h34});
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp idle", {30'd0, bus.busy, bus.res_valid}, 32'd0);

        // Round robin with all requesters active
        doReset();
        applyStimulus(4'b1111, 32'h04030201, 32'h10101010);
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            waitGnt(g, w);
            checkOutput("rr order", 32'(g), 32'(4'b0001 << (k % 4)));
            if (k > 0) checkOutput("rr spacing", cyc - prev_cyc, 11);
            prev_cyc = cyc;
            bus.req[k % 4] = 1'b0;
            @(negedge clk);
            bus.req[k % 4] = 1'b1;
        end
        bus.req = '0;

        // Reset during the 4th ADD cycle
        doReset();
        applyStimulus(4'b0001, 32'h00000055, 32'h00000022);
        waitGnt(g, w);
        checkOutput("rst gnt", 32'(g), 32'h1);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst immediate",
                    {19'd0, bus.gnt, bus.busy, bus.res_valid, bus.res_cout, bus.res_id, bus.res}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy || bus.gnt != '0) quiet++;
        end
        checkOutput("rst no result", quiet, 0);
        applyStimulus(4'b0001, 32'h00000001, 32'h00000001);
        runOp("rst fresh", 4'b0001, 8'h02, 1'b0, 2'd0, 4'b0000);
        @(negedge clk);

        // Request raised while busy is held off until after the handshake
        doReset();
        applyStimulus(4'b0001, 32'h00040010, 32'h00030020);
        runOp("late req0", 4'b0001, 8'h30, 1'b0, 2'd0, 4'b0100);
        @(negedge clk);
        checkOutput("late idle", {31'd0, bus.busy}, 32'd0);
        waitGnt(g, w);
        checkOutput("late gnt2", 32'(g), 32'h4);
        checkOutput("late gnt2 delay", w, 1);
        bus.req = '0;
        begin
            int lat;
            int extra;
            waitResult(lat, extra);
            checkOutput("late req2 latency", lat, 9);
            checkOutput("late req2 res", 32'(bus.res), 32'h07);
            checkOutput("late req2 id", 32'(bus.res_id), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 8: operand width, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 req  input  NREQ  per-requester add request, level; held until the matching gnt bit is seen.
REQ-006 a_in  input  NREQ*WIDTH  packed operand A; slice i belongs to requester i.
REQ-007 b_in  input  NREQ*WIDTH  packed operand B; slice i belongs to requester i.
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse marking the operand-capture cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res  output  WIDTH  sum, modulo 2^WIDTH.
REQ-013 res_cout  output  1  carry out of the MSB.
REQ-014 res_id  output  clog2(NREQ)  index of the requester that owns res.

Function
REQ-015 The block shall implement an FSM with states IDLE, ADD and DONE, one-hot or binary, with no other reachable states.
REQ-016 IDLE: if any req bit is high at an edge, the block shall, at that edge:
- select the winner round-robin, starting from the pointer ptr;
- capture the winner's a/b slices and its index;
- clear carry and the bit counter;
- move to ADD.
REQ-017 gnt[winner] shall be high for exactly the cycle following that capture edge; gnt shall be 0 at all other times.
REQ-018 req bits that change while the FSM is not in IDLE shall have no effect; requests are sampled only in IDLE.
REQ-019 ADD shall last exactly WIDTH cycles; each cycle processes one bit, LSB first.
- sum = a0 ^ b0 ^ carry
- carry <= majority(a0, b0, carry)
- sum shifts into res at the MSB end
- the operand registers shift right by 1
REQ-020 After the WIDTH-th ADD cycle the FSM shall enter DONE with res_valid = 1, i.e. WIDTH+1 edges after the capture edge.
- res holds the full sum.
- res_cout holds the final carry.
REQ-021 In DONE, res, res_cout and res_id shall stay stable while res_valid = 1 and res_ready = 0.
REQ-022 On the edge where res_valid and res_ready are both 1:
- res_valid shall drop;
- ptr shall become (winner+1) mod NREQ;
- the FSM shall return to IDLE.
REQ-023 A new request shall not be captured in the same edge as the DONE handshake; the minimum spacing between gnt pulses is WIDTH+3 cycles.
REQ-024 With a single requester holding req continuously, that requester shall be granted on every arbitration.
REQ-025 No requester that holds req shall wait more than NREQ-1 other grants.
REQ-026 res_ready while not in DONE shall be ignored.

Reset
REQ-027 When rst_n is low, the block shall immediately, without waiting for a clock edge, force:
- state = IDLE, ptr = 0, carry = 0, counter = 0;
- operand registers and res = 0, res_cout = 0, res_id = 0;
- gnt = 0, res_valid = 0, busy = 0.
REQ-028 Reset asserted mid-ADD or mid-DONE shall abandon the operation without issuing any result.
REQ-029 After rst_n rises, the first capture shall occur no earlier than the first rising edge of clk with rst_n high.

Structure
REQ-030 A shared package, serial_add_pkg, shall hold:
- the state encoding constants IDLE/ADD/DONE;
- the default WIDTH and NREQ values.
REQ-031 The bit-serial datapath (operand shift registers, carry, result shift register, bit counter) shall be a sub-module, serial_add_core.
- Its control inputs are load and step.
- Its outputs are res, cout and last_bit.
REQ-032 The round-robin arbiter and the FSM shall live in serial_add_sched itself.
REQ-033 All sequential logic in both modules shall use the same clk and asynchronous rst_n.

Verification
REQ-034 Basic add: req=0001, a0=0x5A, b0=0x3C, res_ready=1. Required response:
- gnt=0001 for one cycle;
- 9 edges after capture, res_valid=1 with res=0x96, res_cout=0, res_id=0.
REQ-035 Carry out: req=0010, a1=0xFF, b1=0x01. Required response: res=0x00, res_cout=1, res_id=1.
REQ-036 Round-robin: req=1111 held high, each requester dropping its req for 1 cycle after its gnt. Required response:
- grant order 0,1,2,3,0;
- gnt pulses 11 cycles apart.
REQ-037 Backpressure: res_ready=0 for 5 cycles in DONE. Required response:
- res_valid stays 1;
- res, res_cout and res_id are unchanged;
- busy=1 throughout;
- IDLE is entered the edge after res_ready=1.
REQ-038 Reset mid-ADD: pull rst_n low at the 4th ADD cycle. Required response:
- all outputs are 0 immediately;
- no res_valid pulse appears;
- the next request after release gets a fresh result, e.g. 0x01+0x01 = 0x02.
REQ-039 Ignored request: raise req=0100 during ADD of requester 0. Required response: requester 2 is granted only after requester 0's DONE handshake.
